aes_key_sched_ctrl: RTL and testbench

Sequential AES-128 key-expansion controller. Accepts a 128-bit cipher key over a valid/ready handshake and walks rounds 1..10. Each round it drives the round index to the round-constant unit and RotWord(w3) to an external SubWord S-box unit, then combines the results into the next round key. Round keys 0..10 stream out over a second valid/ready handshake to the cipher datapath or a key store.

---
 rtl/aes_key_sched_ctrl.sv | 141 ++++++++++++++
 tb/tb_aes_key_sched_ctrl.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-expansion controller: walks rounds 1..10 using an external
// SubWord unit and round-constant unit, streaming round keys 0..10 out.
module aes_key_sched_ctrl #(
    parameter int SBOX_LAT   = 0,
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         abort_i,
    input  logic         key_valid_i,
    output logic         key_ready_o,
    input  logic [127:0] key_i,
    output logic [3:0]   rc_round_o,
    input  logic [31:0]  rc_word_i,
    output logic [31:0]  sub_word_o,
    input  logic [31:0]  sub_word_i,
    output logic         rk_valid_o,
    input  logic         rk_ready_i,
    output logic [127:0] rk_o,
    output logic [3:0]   rk_idx_o,
    output logic         busy_o,
    output logic         done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        SUB  = 2'd2
    } state_e;

    localparam int              WAIT_W    = (SBOX_LAT < 1) ? 1 : $clog2(SBOX_LAT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SBOX_LAT);
    localparam logic [3:0]      LAST_IDX  = 4'(NUM_ROUNDS);

    state_e              state_q, state_d;
    logic [127:0]        key_q, key_d;
    logic [3:0]          idx_q, idx_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                done_q, done_d;
    logic [3:0]          rc_round_q, rc_round_d;
    logic [31:0]         sub_word_q, sub_word_d;

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // Chained XOR: each new word folds in the freshly computed previous word.
    function automatic logic [127:0] next_round_key(input logic [127:0] rk,
                                                    input logic [31:0]  t);
        logic [31:0] w0n, w1n, w2n, w3n;
        w0n = rk[127:96] ^ t;
        w1n = rk[95:64]  ^ w0n;
        w2n = rk[63:32]  ^ w1n;
        w3n = rk[31:0]   ^ w2n;
        return {w0n, w1n, w2n, w3n};
    endfunction

    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        idx_d      = idx_q;
        wait_d     = wait_q;
        done_d     = 1'b0;
        rc_round_d = rc_round_q;
        sub_word_d = sub_word_q;

        if (abort_i) begin
            state_d    = IDLE;
            key_d      = '0;
            idx_d      = '0;
            wait_d     = '0;
            rc_round_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (key_valid_i) begin
                        key_d   = key_i;
                        idx_d   = '0;
                        state_d = EMIT;
                    end
                end
                EMIT: begin
                    if (rk_ready_i) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            // S-box operand and round index are launched on entry so
                            // they are stable for the whole SUB stay.
                            state_d    = SUB;
                            wait_d     = '0;
                            rc_round_d = idx_q + 4'd1;
                            sub_word_d = rot_word(key_q[31:0]);
                        end
                    end
                end
                SUB: begin
                    if (wait_q == WAIT_LAST) begin
                        key_d      = next_round_key(key_q, sub_word_i ^ rc_word_i);
                        idx_d      = idx_q + 4'd1;
                        rc_round_d = '0;
                        state_d    = EMIT;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            key_q      <= '0;
            idx_q      <= '0;
            wait_q     <= '0;
            done_q     <= 1'b0;
            rc_round_q <= '0;
            sub_word_q <= '0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            idx_q      <= idx_d;
            wait_q     <= wait_d;
            done_q     <= done_d;
            rc_round_q <= rc_round_d;
            sub_word_q <= sub_word_d;
        end
    end

    assign key_ready_o = (state_q == IDLE);
    assign rk_valid_o  = (state_q == EMIT);
    assign busy_o      = (state_q != IDLE);
    assign rk_o        = key_q;
    assign rk_idx_o    = idx_q;
    assign rc_round_o  = rc_round_q;
    assign sub_word_o  = sub_word_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl: two instances (combinational and 2-cycle S-box)
// checked against a FIPS-197 key-expansion model computed from GF(2^8) arithmetic.
module tb_aes_key_sched_ctrl;

    logic         clk, rst_n, abort, kv, rdy, sel;
    logic [127:0] key_in;

    logic         key_ready0, rk_valid0, busy0, done0;
    logic [3:0]   rc_round0, rk_idx0;
    logic [31:0]  sub_o0, sub_i0, rc_w0;
    logic [127:0] rk0;

    logic         key_ready2, rk_valid2, busy2, done2;
    logic [3:0]   rc_round2, rk_idx2;
    logic [31:0]  sub_o2, sub_i2, rc_w2, s1, s2;
    logic [127:0] rk2;

    logic         key_ready_s, rk_valid_s, busy_s, done_s;
    logic [3:0]   rc_round_s, rk_idx_s;
    logic [31:0]  sub_s;
    logic [127:0] rk_s;

    logic [127:0] model_rk [0:10];
    logic [127:0] got [0:10];
    int n_tests, n_fail;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    aes_key_sched_ctrl #(.SBOX_LAT(0), .NUM_ROUNDS(10)) dut0 (
        .clk(clk), .rst_n(rst_n), .abort_i(abort),
        .key_valid_i(kv && !sel), .key_ready_o(key_ready0), .key_i(key_in),
        .rc_round_o(rc_round0), .rc_word_i(rc_w0),
        .sub_word_o(sub_o0), .sub_word_i(sub_i0),
        .rk_valid_o(rk_valid0), .rk_ready_i(rdy && !sel),
        .rk_o(rk0), .rk_idx_o(rk_idx0), .busy_o(busy0), .done_o(done0)
    );

    aes_key_sched_ctrl #(.SBOX_LAT(2), .NUM_ROUNDS(10)) dut2 (
        .clk(clk), .rst_n(rst_n), .abort_i(abort),
        .key_valid_i(kv && sel), .key_ready_o(key_ready2), .key_i(key_in),
        .rc_round_o(rc_round2), .rc_word_i(rc_w2),
        .sub_word_o(sub_o2), .sub_word_i(sub_i2),
        .rk_valid_o(rk_valid2), .rk_ready_i(rdy && sel),
        .rk_o(rk2), .rk_idx_o(rk_idx2), .busy_o(busy2), .done_o(done2)
    );

    // ---------------- GF(2^8) reference arithmetic ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_f(input logic [7:0] b);
        logic [7:0] inv;
        inv = 8'h00;
        for (int y = 1; y < 256; y++)
            if (gmul(b, 8'(y)) == 8'h01) inv = 8'(y);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword_f(input logic [31:0] w);
        return {sbox_f(w[31:24]), sbox_f(w[23:16]), sbox_f(w[15:8]), sbox_f(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_f(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [7:0] rcon_f(input int r);
        logic [7:0] v;
        v = 8'h01;
        for (int i = 1; i < r; i++) v = gmul(v, 8'h02);
        return v;
    endfunction

    function automatic logic [31:0] rc_unit(input logic [3:0] r);
        if (r >= 4'd1 && r <= 4'd10) return {rcon_f(int'(r)), 24'h0};
        return 32'h0;
    endfunction

    assign sub_i0 = subword_f(sub_o0);
    assign rc_w0  = rc_unit(rc_round0);
    assign rc_w2  = rc_unit(rc_round2);
    assign sub_i2 = s2;

    always @(posedge clk) begin
        s1 <= subword_f(sub_o2);
        s2 <= s1;
    end

    assign key_ready_s = sel ? key_ready2 : key_ready0;
    assign rk_valid_s  = sel ? rk_valid2  : rk_valid0;
    assign busy_s      = sel ? busy2      : busy0;
    assign done_s      = sel ? done2      : done0;
    assign rc_round_s  = sel ? rc_round2  : rc_round0;
    assign rk_idx_s    = sel ? rk_idx2    : rk_idx0;
    assign sub_s       = sel ? sub_o2     : sub_o0;
    assign rk_s        = sel ? rk2        : rk0;

    // Standard word-by-word key expansion, w[0..43].
    task automatic build_model(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        w[0] = k[127:96]; w[1] = k[95:64]; w[2] = k[63:32]; w[3] = k[31:0];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) t = subword_f(rot_f(t)) ^ {rcon_f(i / 4), 24'h0};
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++)
            model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic send_key(input logic [127:0] k);
        bit ok;
        ok = 1'b0; kv = 1'b1; key_in = k;
        for (int i = 0; i < 50; i++) begin
            if (key_ready_s === 1'b1) begin
                @(posedge clk); #1;
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        kv = 1'b0; key_in = {4{$urandom}};
        n_tests++;
        if (!ok || busy_s !== 1'b1) begin
            n_fail++;
            $display("FAIL key_accept: accepted=%0d busy=%b, required accepted=1 busy=1", ok, busy_s);
        end
    endtask

    // Drive rk_ready at pct% and check every observed cycle of one expansion.
    task automatic collect(input logic [127:0] k, input int pct, input bit hold,
                           input logic [127:0] alt);
        int exp_i, last_hs, lat, pi, cyc;
        bit stall, fin;
        logic [127:0] prev_rk;
        logic [3:0] prev_idx;
        build_model(k);
        lat = sel ? 2 : 0;
        exp_i = 0; last_hs = -1; stall = 1'b0; fin = 1'b0;
        prev_rk = '0; prev_idx = '0;
        kv = hold;
        if (hold) key_in = alt;
        for (cyc = 0; cyc < 400; cyc++) begin
            if (exp_i == 11) begin
                n_tests++;
                if (done_s !== 1'b1 || rk_valid_s !== 1'b0 || busy_s !== 1'b0 || key_ready_s !== 1'b1) begin
                    n_fail++;
                    $display("FAIL done_state: done=%b valid=%b busy=%b ready=%b, required 1 0 0 1",
                             done_s, rk_valid_s, busy_s, key_ready_s);
                end
                if (pct == 100) begin
                    n_tests++;
                    if (cyc != 11 + 10 * (lat + 1)) begin
                        n_fail++;
                        $display("FAIL expansion_time: %0d cycles, required %0d", cyc, 11 + 10 * (lat + 1));
                    end
                end
                fin = 1'b1;
                break;
            end
            n_tests++;
            if (done_s !== 1'b0 || busy_s !== 1'b1 || key_ready_s !== 1'b0) begin
                n_fail++;
                $display("FAIL busy_state: done=%b busy=%b key_ready=%b, required 0 1 0 (key %0d)",
                         done_s, busy_s, key_ready_s, exp_i);
            end
            if (rk_valid_s === 1'b1) begin
                if (stall) begin
                    n_tests++;
                    if (rk_s !== prev_rk || rk_idx_s !== prev_idx) begin
                        n_fail++;
                        $display("FAIL hold_stable: rk=%h idx=%0d, required rk=%h idx=%0d",
                                 rk_s, rk_idx_s, prev_rk, prev_idx);
                    end
                end
                n_tests++;
                if (rc_round_s !== 4'd0) begin
                    n_fail++;
                    $display("FAIL rc_round_emit: %0d, required 0", rc_round_s);
                end
                rdy = (int'($urandom_range(0, 99)) < pct);
                if (rdy) begin
                    n_tests++;
                    if (rk_idx_s !== 4'(exp_i) || rk_s !== model_rk[exp_i]) begin
                        n_fail++;
                        $display("FAIL round_key: idx=%0d rk=%h, required idx=%0d rk=%h",
                                 rk_idx_s, rk_s, exp_i, model_rk[exp_i]);
                    end
                    got[exp_i] = rk_s;
                    if (pct == 100 && last_hs >= 0) begin
                        n_tests++;
                        if (cyc - last_hs != lat + 2) begin
                            n_fail++;
                            $display("FAIL valid_spacing: %0d cycles, required %0d", cyc - last_hs, lat + 2);
                        end
                    end
                    last_hs = cyc;
                    exp_i++;
                end
                stall = !rdy; prev_rk = rk_s; prev_idx = rk_idx_s;
            end else begin
                rdy = 1'($urandom_range(0, 1));
                pi = (exp_i > 0) ? exp_i - 1 : 0;
                n_tests++;
                if (exp_i == 0 || rc_round_s !== 4'(exp_i) || sub_s !== rot_f(model_rk[pi][31:0])) begin
                    n_fail++;
                    $display("FAIL sub_phase: rc_round=%0d sub_word=%h, required rc_round=%0d sub_word=%h",
                             rc_round_s, sub_s, exp_i, rot_f(model_rk[pi][31:0]));
                end
                stall = 1'b0;
            end
            @(posedge clk); #1;
        end
        rdy = 1'b0;
        kv = 1'b0;
        if (!fin) begin
            n_tests++; n_fail++;
            $display("FAIL expansion_timeout: %0d keys seen, required 11", exp_i);
        end
    endtask

    task automatic check_reset_values(input string tag);
        n_tests++;
        if (key_ready0 !== 1'b1 || rk_valid0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0 ||
            rk_idx0 !== 4'd0 || rc_round0 !== 4'd0 || sub_o0 !== 32'h0 || rk0 !== 128'h0 ||
            key_ready2 !== 1'b1 || rk_valid2 !== 1'b0 || busy2 !== 1'b0 || rk2 !== 128'h0 ||
            sub_o2 !== 32'h0) begin
            n_fail++;
            $display("FAIL %s: ready=%b valid=%b busy=%b done=%b idx=%0d rc=%0d sub=%h rk=%h, required 1 0 0 0 0 0 0 0",
                     tag, key_ready0, rk_valid0, busy0, done0, rk_idx0, rc_round0, sub_o0, rk0);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2 check_reset_values("reset_state");
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset_values("reset_release_idle");
    endtask

    task automatic test_fips();
        sel = 1'b0;
        send_key(FIPS_KEY);
        collect(FIPS_KEY, 100, 1'b0, '0);
        n_tests++;
        if (got[0] !== FIPS_KEY || got[1] !== 128'ha0fafe1788542cb123a339392a6c7605 ||
            got[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            n_fail++;
            $display("FAIL fips_vectors: rk0=%h rk1=%h rk10=%h", got[0], got[1], got[10]);
        end
        @(posedge clk); #1;
        n_tests++;
        if (done_s !== 1'b0 || key_ready_s !== 1'b1) begin
            n_fail++;
            $display("FAIL done_pulse_width: done=%b ready=%b, required done=0 ready=1", done_s, key_ready_s);
        end
    endtask

    task automatic test_ready_toggle();
        sel = 1'b0;
        send_key(FIPS_KEY);
        collect(FIPS_KEY, 45, 1'b0, '0);
        @(posedge clk); #1;
    endtask

    task automatic test_sbox_latency();
        sel = 1'b1;
        send_key(FIPS_KEY);
        collect(FIPS_KEY, 100, 1'b0, '0);
        n_tests++;
        if (got[1] !== 128'ha0fafe1788542cb123a339392a6c7605 ||
            got[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            n_fail++;
            $display("FAIL sbox_lat_vectors: rk1=%h rk10=%h", got[1], got[10]);
        end
        @(posedge clk); #1;
        sel = 1'b0;
    endtask

    task automatic test_abort();
        int hs;
        bit seen_bad;
        sel = 1'b0;
        send_key(FIPS_KEY);
        rdy = 1'b1; hs = 0;
        for (int i = 0; i < 40 && hs < 5; i++) begin
            if (rk_valid_s === 1'b1) hs++;
            @(posedge clk); #1;
        end
        rdy = 1'b0;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        n_tests++;
        if (hs != 5 || rk_valid_s !== 1'b0 || busy_s !== 1'b0 || key_ready_s !== 1'b1 ||
            done_s !== 1'b0 || rk_s !== 128'h0) begin
            n_fail++;
            $display("FAIL abort_idle: handshakes=%0d valid=%b busy=%b ready=%b done=%b rk=%h, required 5 0 0 1 0 0",
                     hs, rk_valid_s, busy_s, key_ready_s, done_s, rk_s);
        end
        seen_bad = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (done_s !== 1'b0 || rk_valid_s !== 1'b0) seen_bad = 1'b1;
            @(posedge clk); #1;
        end
        n_tests++;
        if (seen_bad) begin
            n_fail++;
            $display("FAIL abort_quiet: done/valid seen=1, required 0");
        end
        kv = 1'b1; abort = 1'b1; key_in = FIPS_KEY;
        @(posedge clk); #1;
        kv = 1'b0; abort = 1'b0;
        n_tests++;
        if (key_ready_s !== 1'b1 || busy_s !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_blocks_key: ready=%b busy=%b, required 1 0", key_ready_s, busy_s);
        end
        send_key(128'h0);
        collect(128'h0, 100, 1'b0, '0);
        n_tests++;
        if (got[1] !== 128'h62636363626363636263636362636363) begin
            n_fail++;
            $display("FAIL zero_key_rk1: %h, required 62636363626363636263636362636363", got[1]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_busy_key_ignored();
        logic [127:0] k2;
        sel = 1'b0;
        k2 = {4{$urandom}};
        send_key(FIPS_KEY);
        collect(FIPS_KEY, 70, 1'b1, k2);
        kv = 1'b1; key_in = k2;
        @(posedge clk); #1;
        kv = 1'b0;
        n_tests++;
        if (busy_s !== 1'b1 || rk_valid_s !== 1'b1 || rk_s !== k2 || rk_idx_s !== 4'd0) begin
            n_fail++;
            $display("FAIL second_key_after_done: busy=%b valid=%b rk=%h idx=%0d, required 1 1 %h 0",
                     busy_s, rk_valid_s, rk_s, rk_idx_s, k2);
        end
        collect(k2, 100, 1'b0, '0);
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_sub();
        int hs;
        logic [127:0] k;
        sel = 1'b0;
        k = {4{$urandom}};
        send_key(k);
        rdy = 1'b1; hs = 0;
        for (int i = 0; i < 30; i++) begin
            if (rk_valid_s === 1'b0 && hs >= 3) break;
            if (rk_valid_s === 1'b1) hs++;
            @(posedge clk); #1;
        end
        n_tests++;
        if (busy_s !== 1'b1 || rk_valid_s !== 1'b0 || hs < 3) begin
            n_fail++;
            $display("FAIL reach_sub: busy=%b valid=%b handshakes=%0d, required 1 0 >=3", busy_s, rk_valid_s, hs);
        end
        #2 rst_n = 1'b0;
        #1 check_reset_values("async_reset_mid_sub");
        rdy = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        k = {4{$urandom}};
        send_key(k);
        collect(k, 100, 1'b0, '0);
        @(posedge clk); #1;
    endtask

    task automatic test_random_keys();
        logic [127:0] k;
        int pct;
        for (int n = 0; n < 4; n++) begin
            sel = 1'($urandom_range(0, 1));
            k = {4{$urandom}};
            pct = int'($urandom_range(30, 100));
            send_key(k);
            collect(k, pct, 1'b0, '0);
            @(posedge clk); #1;
        end
        sel = 1'b0;
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        abort = 1'b0; kv = 1'b0; rdy = 1'b0; sel = 1'b0; key_in = '0;
        test_reset();
        test_fips();
        test_ready_toggle();
        test_sbox_latency();
        test_abort();
        test_busy_key_ignored();
        test_reset_mid_sub();
        test_random_keys();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
